// File: rtl/div_pkg.sv
// Shared types and constants for the clock-divider controller.
package div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_SWITCH = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    DUTY_HALF = 2'd0,
    DUTY_LOW  = 2'd1,
    DUTY_HIGH = 2'd2,
    DUTY_RSVD = 2'd3
  } duty_t;

  localparam int unsigned N_MIN = 2;

endpackage

// File: rtl/div_duty_calc.sv
// High-phase length and half-cycle extend flag for a divide ratio and duty mode.
module div_duty_calc
  import div_pkg::*;
#(
  parameter int unsigned CNT_W = 4
) (
  input  logic [CNT_W-1:0] n,
  input  duty_t            mode,
  output logic [CNT_W-1:0] h_c,
  output logic             ext_c
);

  logic [CNT_W-1:0] third;
  logic [CNT_W-1:0] third_min;

  always_comb begin
    third     = n / CNT_W'(3);
    // Keep at least one high cycle for small ratios in the 1/3 and 2/3 modes.
    third_min = (third == '0) ? CNT_W'(1) : third;
    h_c       = n >> 1;
    ext_c     = n[0];
    case (mode)
      DUTY_LOW: begin
        h_c   = third_min;
        ext_c = 1'b0;
      end
      DUTY_HIGH: begin
        h_c   = n - third_min;
        ext_c = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/div_ctrl.sv
// Divider controller: config handshake, period counter and glitch-free ratio/duty switching.
module div_ctrl
  import div_pkg::*;
#(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic [1:0]       cfg_duty,
  input  logic             cfg_en,
  output logic             cfg_err,
  output logic             phase_p,
  output logic             ext_en,
  output logic             period_end,
  output logic             running
);

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [CNT_W-1:0] n_q, n_d;
  duty_t            mode_q, mode_d;
  logic [CNT_W-1:0] pend_n, pend_n_d;
  duty_t            pend_mode, pend_mode_d;
  logic             pend_en, pend_en_d;

  logic phase_p_d, ext_en_d, period_end_d, running_d, cfg_err_d, cfg_ready_d;

  logic [CNT_W-1:0] h_c;
  logic             ext_c;
  logic             accept_c, bad_c, take_c, wrap_c;

  div_duty_calc #(.CNT_W(CNT_W)) u_duty (
    .n     (n_q),
    .mode  (mode_q),
    .h_c   (h_c),
    .ext_c (ext_c)
  );

  assign accept_c = cfg_valid && cfg_ready;
  assign bad_c    = (32'(cfg_div) < N_MIN) || (duty_t'(cfg_duty) == DUTY_RSVD);
  assign take_c   = accept_c && !bad_c;
  assign wrap_c   = (cnt == n_q - CNT_W'(1));

  // Next-state and next-output logic; outputs trail cnt by one cycle.
  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    n_d          = n_q;
    mode_d       = mode_q;
    pend_n_d     = pend_n;
    pend_mode_d  = pend_mode;
    pend_en_d    = pend_en;
    phase_p_d    = 1'b0;
    ext_en_d     = 1'b0;
    period_end_d = 1'b0;
    running_d    = (state != ST_IDLE);
    cfg_err_d    = accept_c && bad_c;

    if (state != ST_IDLE) begin
      phase_p_d    = (cnt < h_c);
      ext_en_d     = ext_c;
      period_end_d = wrap_c;
      cnt_d        = wrap_c ? '0 : cnt + CNT_W'(1);
    end

    case (state)
      ST_IDLE: begin
        if (take_c && cfg_en) begin
          n_d     = cfg_div;
          mode_d  = duty_t'(cfg_duty);
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (take_c) begin
          pend_n_d    = cfg_div;
          pend_mode_d = duty_t'(cfg_duty);
          pend_en_d   = cfg_en;
          state_d     = ST_SWITCH;
        end
      end
      ST_SWITCH: begin
        // The old configuration owns the current period until it wraps.
        if (wrap_c) begin
          n_d    = pend_n;
          mode_d = pend_mode;
          if (pend_en) begin
            state_d = ST_RUN;
          end else begin
            state_d   = ST_IDLE;
            phase_p_d = 1'b0;
            ext_en_d  = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    cfg_ready_d = (state_d != ST_SWITCH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      n_q        <= CNT_W'(N_MIN);
      mode_q     <= DUTY_HALF;
      pend_n     <= CNT_W'(N_MIN);
      pend_mode  <= DUTY_HALF;
      pend_en    <= 1'b0;
      phase_p    <= 1'b0;
      ext_en     <= 1'b0;
      period_end <= 1'b0;
      running    <= 1'b0;
      cfg_err    <= 1'b0;
      cfg_ready  <= 1'b1;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      n_q        <= n_d;
      mode_q     <= mode_d;
      pend_n     <= pend_n_d;
      pend_mode  <= pend_mode_d;
      pend_en    <= pend_en_d;
      phase_p    <= phase_p_d;
      ext_en     <= ext_en_d;
      period_end <= period_end_d;
      running    <= running_d;
      cfg_err    <= cfg_err_d;
      cfg_ready  <= cfg_ready_d;
    end
  end

endmodule
